// File: rtl/startup_pkg.sv
// Shared types for the STARTUPE2 CCLK/DONE controller: FSM state encoding
// and the DONE pin drive modes.
package startup_pkg;

    typedef enum logic [1:0] {
        ST_WAIT     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_IDLE     = 2'd2,
        ST_BURST    = 2'd3
    } state_e;

    localparam logic [1:0] DONE_HIZ   = 2'd0;
    localparam logic [1:0] DONE_LOW   = 2'd1;
    localparam logic [1:0] DONE_HIGH  = 2'd2;
    localparam logic [1:0] DONE_BLINK = 2'd3;

endpackage

// File: rtl/STARTUPE2.sv
// Behavioural stand-in for the Xilinx STARTUPE2 primitive. Only EOS is
// modelled; it is a plain variable the simulation environment can set to
// mimic the end of the configuration startup sequence.
module STARTUPE2 (
    input  logic CLK,
    input  logic GSR,
    input  logic GTS,
    input  logic KEYCLEARB,
    input  logic PACK,
    input  logic USRCCLKO,
    input  logic USRCCLKTS,
    input  logic USRDONEO,
    input  logic USRDONETS,
    output logic EOS
);

    logic sim_eos = 1'b0;
    logic unused_pins;

    assign EOS         = sim_eos;
    assign unused_pins = ^{CLK, GSR, GTS, KEYCLEARB, PACK, USRCCLKO,
                           USRCCLKTS, USRDONEO, USRDONETS};

endmodule

// File: rtl/cclk_pulse_gen.sv
// CCLK waveform generator: a phase counter divides clk into CCLK periods
// (high first half, low second half) and a pulse counter counts completed
// periods against a latched length. Both counters sit at zero while idle.
module cclk_pulse_gen
#(
    parameter int CCLK_DIV = 4,
    parameter int LEN_W    = 16
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_load,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_cclk,
    output logic             o_pulse,
    output logic             o_last,
    output logic             o_len_zero
);

    localparam int PH_W = (CCLK_DIV > 2) ? $clog2(CCLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CCLK_DIV - 1);
    localparam logic [PH_W-1:0] PH_HALF = PH_W'(CCLK_DIV / 2);

    logic [PH_W-1:0]  r_phase;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;

    // Phase and pulse counters advance only while running; idle clears them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_cnt   <= '0;
        end else if (!i_run) begin
            r_phase <= '0;
            r_cnt   <= '0;
        end else if (r_phase == PH_LAST) begin
            r_phase <= '0;
            r_cnt   <= r_cnt + LEN_W'(1);
        end else begin
            r_phase <= r_phase + PH_W'(1);
        end
    end

    // Length is captured when a preamble or burst is accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len <= '0;
        end else if (i_load) begin
            r_len <= i_len;
        end
    end

    // A zero length suppresses every CCLK edge.
    assign o_len_zero = (r_len == '0);
    assign o_cclk     = i_run && !o_len_zero && (r_phase < PH_HALF);
    assign o_pulse    = i_run && !o_len_zero && (r_phase == PH_LAST);
    assign o_last     = o_pulse && (r_cnt == (r_len - LEN_W'(1)));

endmodule

// File: rtl/startup_cclk_ctrl.sv
// Post-configuration owner of USRCCLKO and DONE. Waits for EOS and PLL
// lock, emits a preamble of CCLK pulses, then serves CCLK bursts on a
// level request. Any loss of lock drops back to WAIT and replays the
// preamble on re-lock.
// Handshake: burst_req is a level; in IDLE it is accepted immediately,
// burst_ack pulses on the first BURST cycle, burst_done pulses on the first
// IDLE cycle after the final low phase; a held request is re-accepted after
// exactly one IDLE cycle.
module startup_cclk_ctrl
    import startup_pkg::*;
#(
    parameter int CCLK_DIV     = 4,
    parameter int PREAMBLE_CYC = 3,
    parameter int LEN_W        = 16,
    parameter int BLINK_LOG2   = 22
)
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_locked,
    input  logic [1:0]       i_done_mode,
    input  logic             i_burst_req,
    input  logic [LEN_W-1:0] i_burst_len,
    output logic             o_burst_ack,
    output logic             o_burst_done,
    output logic             o_busy,
    output logic             o_ready,
    output logic             o_aborted,
    output logic             o_cclk_mon,
    output logic [1:0]       o_dbg_state
);

    state_e                r_state;
    state_e                w_state_next;
    logic [1:0]            r_eos_sync;
    logic [1:0]            r_lock_sync;
    logic                  r_eos_seen;
    logic                  r_ack;
    logic                  r_done;
    logic                  r_aborted;
    logic [BLINK_LOG2-1:0] r_blink_cnt;
    logic                  r_donets;
    logic                  r_doneo;

    logic                  w_eos;
    logic                  w_eos_s;
    logic                  w_lock_s;
    logic                  w_eos_ok;
    logic                  w_run;
    logic                  w_load;
    logic [LEN_W-1:0]      w_load_len;
    logic                  w_cclk;
    logic                  w_last;
    logic                  w_len_zero;
    logic                  w_unused_pulse;

    assign w_eos_s  = r_eos_sync[1];
    assign w_lock_s = r_lock_sync[1];
    // EOS only has to be seen once per reset.
    assign w_eos_ok = r_eos_seen || w_eos_s;
    assign w_run    = (r_state == ST_PREAMBLE) || (r_state == ST_BURST);

    // Two-flop synchronisers for EOS and PLL lock, plus the sticky EOS flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_eos_sync  <= 2'b00;
            r_lock_sync <= 2'b00;
            r_eos_seen  <= 1'b0;
        end else begin
            r_eos_sync  <= {r_eos_sync[0], w_eos};
            r_lock_sync <= {r_lock_sync[0], i_locked};
            r_eos_seen  <= r_eos_seen || w_eos_s;
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and counter-load decode; lock loss overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_len   = '0;
        case (r_state)
            ST_WAIT: begin
                if (w_eos_ok && w_lock_s) begin
                    w_state_next = ST_PREAMBLE;
                    w_load       = 1'b1;
                    w_load_len   = LEN_W'(PREAMBLE_CYC);
                end
            end
            ST_PREAMBLE: begin
                if (w_last || w_len_zero) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (i_burst_req) begin
                    w_state_next = ST_BURST;
                    w_load       = 1'b1;
                    w_load_len   = i_burst_len;
                end
            end
            ST_BURST: begin
                if (w_last || w_len_zero) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_WAIT;
            end
        endcase
        if (!w_lock_s) begin
            w_state_next = ST_WAIT;
            w_load       = 1'b0;
        end
    end

    // Handshake and abort pulses, each high for the state-entry cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_ack     <= (r_state == ST_IDLE)  && (w_state_next == ST_BURST);
            r_done    <= (r_state == ST_BURST) && (w_state_next == ST_IDLE);
            r_aborted <= w_run && !w_lock_s;
        end
    end

    // Free-running blink counter for DONE mode 3.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_LOG2'(1);
        end
    end

    // Registered DONE pin drive; reset leaves the pin released (hi-z).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_donets <= 1'b1;
            r_doneo  <= 1'b0;
        end else begin
            case (i_done_mode)
                DONE_HIZ: begin
                    r_donets <= 1'b1;
                    r_doneo  <= 1'b0;
                end
                DONE_LOW: begin
                    r_donets <= 1'b0;
                    r_doneo  <= 1'b0;
                end
                DONE_HIGH: begin
                    r_donets <= 1'b0;
                    r_doneo  <= 1'b1;
                end
                DONE_BLINK: begin
                    r_donets <= 1'b0;
                    r_doneo  <= r_blink_cnt[BLINK_LOG2-1];
                end
                default: begin
                    r_donets <= 1'b1;
                    r_doneo  <= 1'b0;
                end
            endcase
        end
    end

    cclk_pulse_gen #(
        .CCLK_DIV (CCLK_DIV),
        .LEN_W    (LEN_W)
    ) u_pulse_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_run      (w_run),
        .i_load     (w_load),
        .i_len      (w_load_len),
        .o_cclk     (w_cclk),
        .o_pulse    (w_unused_pulse),
        .o_last     (w_last),
        .o_len_zero (w_len_zero)
    );

    STARTUPE2 u_startup (
        .CLK       (1'b0),
        .GSR       (1'b0),
        .GTS       (1'b0),
        .KEYCLEARB (1'b1),
        .PACK      (1'b0),
        .USRCCLKO  (w_cclk),
        .USRCCLKTS (1'b0),
        .USRDONEO  (r_doneo),
        .USRDONETS (r_donets),
        .EOS       (w_eos)
    );

    assign o_burst_ack  = r_ack;
    assign o_burst_done = r_done;
    assign o_busy       = w_run;
    assign o_ready      = (r_state == ST_IDLE) || (r_state == ST_BURST);
    assign o_aborted    = r_aborted;
    assign o_cclk_mon   = w_cclk;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_startup_cclk_ctrl.sv
// Directed bench for startup_cclk_ctrl: table of per-cycle vectors for the
// burst handshake plus hand-written sequences for startup, lock loss, DONE
// modes and asynchronous reset.
module tb_startup_cclk_ctrl;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             locked;
  logic [1:0]       done_mode;
  logic             burst_req;
  logic [LEN_W-1:0] burst_len;
  logic             burst_ack;
  logic             burst_done;
  logic             busy;
  logic             ready;
  logic             aborted;
  logic             cclk_mon;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic             req;
    logic [LEN_W-1:0] len;
    logic             cclk;
    logic             busy;
    logic             ready;
    logic             ack;
    logic             done;
    logic             abrt;
  } vec_t;

  vec_t vecs[$];

  // clock/reset block
  always #5 clk = ~clk;

  startup_cclk_ctrl #(
    .CCLK_DIV     (4),
    .PREAMBLE_CYC (3),
    .LEN_W        (LEN_W),
    .BLINK_LOG2   (4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_locked     (locked),
    .i_done_mode  (done_mode),
    .i_burst_req  (burst_req),
    .i_burst_len  (burst_len),
    .o_burst_ack  (burst_ack),
    .o_burst_done (burst_done),
    .o_busy       (busy),
    .o_ready      (ready),
    .o_aborted    (aborted),
    .o_cclk_mon   (cclk_mon),
    .o_dbg_state  (dbg_state)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input logic [1:0] exp);
    n_checks++;
    if (dbg_state !== exp) begin
      n_errors++;
      $display("FAIL %s: state got %0d expected %0d", name, dbg_state, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic c, input logic b,
                            input logic r, input logic a, input logic d,
                            input logic ab);
    check_bit({tag, ".cclk"},  cclk_mon,   c);
    check_bit({tag, ".busy"},  busy,       b);
    check_bit({tag, ".ready"}, ready,      r);
    check_bit({tag, ".ack"},   burst_ack,  a);
    check_bit({tag, ".done"},  burst_done, d);
    check_bit({tag, ".abrt"},  aborted,    ab);
  endtask

  function automatic void add_vec(input logic rq, input logic [LEN_W-1:0] ln,
                                  input logic c, input logic b, input logic r,
                                  input logic a, input logic d, input logic ab);
    vec_t v;
    v.req = rq; v.len = ln; v.cclk = c; v.busy = b;
    v.ready = r; v.ack = a; v.done = d; v.abrt = ab;
    vecs.push_back(v);
  endfunction

  // driver: apply each vector for one edge, then compare
  task automatic run_table(input string tag);
    for (int i = 0; i < vecs.size(); i++) begin
      burst_req = vecs[i].req;
      burst_len = vecs[i].len;
      tick();
      check_outs($sformatf("%s[%0d]", tag, i), vecs[i].cclk, vecs[i].busy,
                 vecs[i].ready, vecs[i].ack, vecs[i].done, vecs[i].abrt);
    end
    vecs.delete();
    burst_req = 1'b0;
  endtask

  // preamble: 3 CCLK periods of 4 clk starting on the PREAMBLE entry cycle
  task automatic check_preamble(input string tag);
    for (int p = 0; p < 12; p++) begin
      if (p > 0) tick();
      check_outs($sformatf("%s_pre[%0d]", tag, p), (p % 4) < 2, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b0);
    end
    tick();
    check_outs({tag, "_idle"}, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_state({tag, "_idle_st"}, 2'd2);
  endtask

  // lock goes high now; PREAMBLE must start on the third edge
  task automatic lock_and_enter(input string tag);
    tick();
    tick();
    check_bit({tag, "_sync_lat"}, busy, 1'b0);
    tick();
    check_state({tag, "_pre_st"}, 2'd1);
  endtask

  logic       blink_prev;
  int         blink_last_edge;
  int         blink_edges;

  initial begin
    rst_n     = 1'b0;
    locked    = 1'b0;
    done_mode = 2'd0;
    burst_req = 1'b0;
    burst_len = '0;

    repeat (3) tick();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("reset_st", 2'd0);
    check_bit("reset_donets", dut.u_startup.USRDONETS, 1'b1);
    check_bit("reset_doneo", dut.u_startup.USRDONEO, 1'b0);
    rst_n = 1'b1;

    while ($time < 100) tick();
    dut.u_startup.sim_eos = 1'b1;
    while ($time < 400) tick();
    check_outs("eos_no_lock", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("eos_no_lock_st", 2'd0);

    locked = 1'b1;
    lock_and_enter("start");
    check_preamble("start");

    // burst of 5: ack on entry, 20 clk of CCLK, done on IDLE entry
    add_vec(1'b1, 16'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int p = 1; p < 20; p++)
      add_vec(1'b0, 16'd0, (p % 4) < 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // zero length: ack then done, no CCLK edge
    add_vec(1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add_vec(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // held request, length 1: one IDLE cycle then re-accepted
    add_vec(1'b1, 16'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int p = 1; p < 4; p++)
      add_vec(1'b1, 16'd1, (p % 4) < 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add_vec(1'b1, 16'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int p = 1; p < 4; p++)
      add_vec(1'b0, 16'd0, (p % 4) < 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_vec(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    add_vec(1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_table("tbl");

    // lock lost after 2 pulses of a 5-pulse burst
    burst_req = 1'b1;
    burst_len = 16'd5;
    tick();
    check_bit("ll_ack", burst_ack, 1'b1);
    burst_req = 1'b0;
    repeat (7) tick();
    check_outs("ll_pulse2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    locked = 1'b0;
    tick();
    check_outs("ll_sync1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("ll_sync2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_outs("ll_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_state("ll_abort_st", 2'd0);
    tick();
    check_outs("ll_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    check_outs("ll_wait", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    locked = 1'b1;
    lock_and_enter("relock");
    check_preamble("relock");

    // DONE modes; new mode visible after one edge
    done_mode = 2'd1;
    tick();
    check_bit("mode1_ts", dut.u_startup.USRDONETS, 1'b0);
    check_bit("mode1_o", dut.u_startup.USRDONEO, 1'b0);
    done_mode = 2'd2;
    tick();
    check_bit("mode2_ts", dut.u_startup.USRDONETS, 1'b0);
    check_bit("mode2_o", dut.u_startup.USRDONEO, 1'b1);
    done_mode = 2'd3;
    tick();
    check_bit("mode3_ts", dut.u_startup.USRDONETS, 1'b0);
    blink_prev      = dut.u_startup.USRDONEO;
    blink_last_edge = -1;
    blink_edges     = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (dut.u_startup.USRDONEO !== blink_prev) begin
        if (blink_last_edge >= 0)
          check_bit($sformatf("blink_gap@%0d", c), (c - blink_last_edge) == 8, 1'b1);
        blink_last_edge = c;
        blink_edges++;
        blink_prev = dut.u_startup.USRDONEO;
      end
    end
    check_bit("blink_edges_ge4", blink_edges >= 4, 1'b1);
    done_mode = 2'd0;
    tick();
    check_bit("mode0_ts", dut.u_startup.USRDONETS, 1'b1);

    // asynchronous reset in the middle of a burst
    done_mode = 2'd2;
    tick();
    burst_req = 1'b1;
    burst_len = 16'd5;
    tick();
    check_bit("rst_burst_ack", burst_ack, 1'b1);
    burst_req = 1'b0;
    tick();
    check_outs("rst_pre", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_state("rst_async_st", 2'd0);
    check_bit("rst_donets", dut.u_startup.USRDONETS, 1'b1);
    check_bit("rst_doneo", dut.u_startup.USRDONEO, 1'b0);
    tick();
    rst_n = 1'b1;
    lock_and_enter("rearm");
    check_bit("rearm_cclk", cclk_mon, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
